weight_load_sched: RTL and testbench



---
 rtl/weight_load_sched_pkg.sv | 25 ++
 rtl/load_beat_counter.sv | 33 +++
 rtl/weight_load_sched.sv | 213 +++++++++++++++++++++
 tb/tb_weight_load_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_load_sched_pkg.sv
// Shared npu package for the weight-load scheduler: FSM state encoding,
// error codes, default tensor count and fixed field widths.
package weight_load_sched_pkg;

  localparam int unsigned MAX_TENSORS = 4;
  localparam int unsigned NUM_W       = 3;
  localparam int unsigned SEL_W       = 3;
  localparam int unsigned CUR_W       = 2;
  localparam int unsigned ERR_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_CFG = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_LONG    = 2'd3
  } err_e;

endpackage

// File: rtl/load_beat_counter.sv
// Per-tensor beat counter with last-beat compare.
// Ports: clk/rst, clr (sync zero, wins over inc), inc, len (tensor length),
//        cnt (current beat index), at_last_c (cnt == len-1, combinational).
module load_beat_counter #(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  at_last_c
);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // len is never 0 while counting and never exceeds 2^ADDR_WIDTH-1, so no wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign at_last_c = (cnt_q == (len - ADDR_WIDTH'(1)));

endmodule

// File: rtl/weight_load_sched.sv
// Weight-load scheduler: accepts a job descriptor of up to MAX_TENSORS tensors,
// then writes each incoming stream beat to SRAM sram_sel at address beat index.
// Ports: cfg_* descriptor handshake, s_axis_* input stream, abort (sync cancel),
//        sram_* registered write port (1-cycle latency), busy/cur_tensor/done
//        status, err_code sticky per job (last error wins).
module weight_load_sched #(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_TENSORS = weight_load_sched_pkg::MAX_TENSORS
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_areset,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [2:0]                        cfg_num,
  input  logic [3*MAX_TENSORS-1:0]          cfg_sram_idx,
  input  logic [ADDR_WIDTH*MAX_TENSORS-1:0] cfg_len,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              abort,
  output logic                              sram_we,
  output logic [2:0]                        sram_sel,
  output logic [ADDR_WIDTH-1:0]             sram_addr,
  output logic [DATA_WIDTH-1:0]             sram_wdata,
  output logic                              busy,
  output logic [1:0]                        cur_tensor,
  output logic                              done,
  output logic [1:0]                        err_code
);

  import weight_load_sched_pkg::*;

  state_e                            state_q, state_d;
  logic [NUM_W-1:0]                  num_q, num_d;
  logic [SEL_W*MAX_TENSORS-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH*MAX_TENSORS-1:0] len_q, len_d;
  logic [CUR_W-1:0]                  cur_q, cur_d;
  logic [ERR_W-1:0]                  err_q, err_d;

  logic                  cfg_ready_q, cfg_ready_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  beat_c, bad_cfg_c, tensor_end_c, wr_c, cnt_clr_c, cnt_inc_c, at_last_c;
  logic [ADDR_WIDTH-1:0] beat_cnt, cur_len;
  logic [SEL_W-1:0]      cur_sel;

  assign beat_c  = s_axis_tvalid && tready_q;
  assign cur_len = len_q[ADDR_WIDTH*cur_q +: ADDR_WIDTH];
  assign cur_sel = idx_q[SEL_W*cur_q +: SEL_W];

  load_beat_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
    .clk       (s_axis_aclk),
    .rst       (s_axis_areset),
    .clr       (cnt_clr_c),
    .inc       (cnt_inc_c),
    .len       (cur_len),
    .cnt       (beat_cnt),
    .at_last_c (at_last_c)
  );

  // Descriptor check: tensor count in range and every used length non-zero
  always_comb begin
    bad_cfg_c = (cfg_num == '0) || (32'(cfg_num) > MAX_TENSORS);
    for (int unsigned i = 0; i < MAX_TENSORS; i++) begin
      if ((i < 32'(cfg_num)) && (cfg_len[ADDR_WIDTH*i +: ADDR_WIDTH] == '0)) bad_cfg_c = 1'b1;
    end
  end

  // State and job registers
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cur_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  // Next-state and job bookkeeping
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    len_d        = len_q;
    cur_d        = cur_q;
    err_d        = err_q;
    tensor_end_c = 1'b0;
    wr_c         = 1'b0;
    cnt_clr_c    = 1'b0;
    cnt_inc_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          num_d     = cfg_num;
          idx_d     = cfg_sram_idx;
          len_d     = cfg_len;
          cur_d     = '0;
          cnt_clr_c = 1'b1;
          err_d     = bad_cfg_c ? ERR_BAD_CFG : ERR_NONE;
          state_d   = bad_cfg_c ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cur_d     = '0;
          cnt_clr_c = 1'b1;
        end else if (beat_c) begin
          wr_c = 1'b1;
          if (s_axis_tlast) begin
            if (!at_last_c) err_d = ERR_SHORT;
            tensor_end_c = 1'b1;
          end else if (at_last_c) begin
            // Counter holds at len-1 while draining; it is cleared at tensor end
            err_d   = ERR_LONG;
            state_d = ST_DRAIN;
          end else begin
            cnt_inc_c = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cur_d     = '0;
          cnt_clr_c = 1'b1;
        end else if (beat_c && s_axis_tlast) begin
          tensor_end_c = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (tensor_end_c) begin
      cnt_clr_c = 1'b1;
      if (NUM_W'(cur_q) == (num_q - NUM_W'(1))) begin
        state_d = ST_DONE;
      end else begin
        cur_d   = cur_q + CUR_W'(1);
        state_d = ST_LOAD;
      end
    end
  end

  // Output next values: status decoded from next state, write port holds when idle
  always_comb begin
    cfg_ready_d = (state_d == ST_IDLE);
    tready_d    = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    we_d        = wr_c;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (wr_c) begin
      sel_d   = cur_sel;
      addr_d  = beat_cnt;
      wdata_d = s_axis_tdata;
    end
  end

  // Output registers
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      cfg_ready_q <= 1'b1;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      tready_q    <= tready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign s_axis_tready = tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sram_we       = we_q;
  assign sram_sel      = sel_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign cur_tensor    = cur_q;
  assign err_code      = err_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched: nominal, SHORT, LONG, BAD_CFG, abort
// and mid-job reset scenarios with hand-computed SRAM write expectations.
module tb_weight_load_sched;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned MT = 4;

  logic            clk;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_num;
  logic [3*MT-1:0] cfg_sram_idx;
  logic [AW*MT-1:0] cfg_len;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic            abort;
  logic            sram_we;
  logic [2:0]      sram_sel;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic            busy;
  logic [1:0]      cur_tensor;
  logic            done;
  logic [1:0]      err_code;

  int checks   = 0;
  int failures = 0;
  int done_n   = 0;
  logic [2:0]    wr_sel[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int wb;
  int db;

  weight_load_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_TENSORS(MT)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_num       (cfg_num),
    .cfg_sram_idx  (cfg_sram_idx),
    .cfg_len       (cfg_len),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .abort         (abort),
    .sram_we       (sram_we),
    .sram_sel      (sram_sel),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .busy          (busy),
    .cur_tensor    (cur_tensor),
    .done          (done),
    .err_code      (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sram_we === 1'b1) begin
      wr_sel.push_back(sram_sel);
      wr_addr.push_back(sram_addr);
      wr_data.push_back(sram_wdata);
    end
    if (done === 1'b1) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [2:0] s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [31:0] obs;
    obs = (k < wr_sel.size()) ? {8'd0, wr_sel[k], wr_addr[k], wr_data[k]} : 32'hFFFF_FFFF;
    chk(tag, obs, {8'd0, s, a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input logic [2:0] n, input logic [3*MT-1:0] idx, input logic [AW*MT-1:0] len);
    int k;
    cfg_num      = n;
    cfg_sram_idx = idx;
    cfg_len      = len;
    cfg_valid    = 1'b1;
    k = 0;
    while (cfg_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("cfg_timeout", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    int k;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    k = 0;
    while (tready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("tready_timeout", 32'(tready), 32'd1);
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_num = '0; cfg_sram_idx = '0; cfg_len = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; abort = 1'b0;
    #2;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_tready",    32'(tready),    32'd0);
    chk("rst_we",        32'(sram_we),   32'd0);
    chk("rst_err",       32'(err_code),  32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Nominal: tensor0 sel3 len4, tensor1 sel1 len2
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd2, {6'd0, 3'd1, 3'd3}, {26'd0, 13'd2, 13'd4});
    chk("nom_busy",   32'(busy),   32'd1);
    chk("nom_tready", 32'(tready), 32'd1);
    beat(8'h10, 1'b0); beat(8'h11, 1'b0); beat(8'h12, 1'b0); beat(8'h13, 1'b1);
    chk("nom_cur1", 32'(cur_tensor), 32'd1);
    beat(8'hA0, 1'b0); beat(8'hA1, 1'b1);
    chk("nom_done_hi", 32'(done), 32'd1);
    tick();
    chk("nom_done_lo",   32'(done),      32'd0);
    chk("nom_cfg_ready", 32'(cfg_ready), 32'd1);
    idle(2);
    chk("nom_wr_cnt", 32'(wr_sel.size() - wb), 32'd6);
    chk_wr("nom_wr0", wb + 0, 3'd3, 13'd0, 8'h10);
    chk_wr("nom_wr3", wb + 3, 3'd3, 13'd3, 8'h13);
    chk_wr("nom_wr4", wb + 4, 3'd1, 13'd0, 8'hA0);
    chk_wr("nom_wr5", wb + 5, 3'd1, 13'd1, 8'hA1);
    chk("nom_done_cnt", 32'(done_n - db), 32'd1);
    chk("nom_err",      32'(err_code),    32'd0);

    // SHORT: len5, tlast on beat 3
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd1, {9'd0, 3'd2}, {39'd0, 13'd5});
    beat(8'h21, 1'b0); beat(8'h22, 1'b0); beat(8'h23, 1'b1);
    idle(3);
    chk("short_wr_cnt", 32'(wr_sel.size() - wb), 32'd3);
    chk_wr("short_wr2", wb + 2, 3'd2, 13'd2, 8'h23);
    chk("short_err",  32'(err_code),    32'd2);
    chk("short_done", 32'(done_n - db), 32'd1);

    // LONG: len2, four beats, tlast on beat 4
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd1, {9'd0, 3'd5}, {39'd0, 13'd2});
    beat(8'h31, 1'b0); beat(8'h32, 1'b0);
    chk("long_err_early", 32'(err_code), 32'd3);
    chk("long_drain_rdy", 32'(tready),   32'd1);
    beat(8'h33, 1'b0); beat(8'h34, 1'b1);
    idle(3);
    chk("long_wr_cnt", 32'(wr_sel.size() - wb), 32'd2);
    chk_wr("long_wr1", wb + 1, 3'd5, 13'd1, 8'h32);
    chk("long_err",       32'(err_code),    32'd3);
    chk("long_done",      32'(done_n - db), 32'd1);
    chk("long_addr_hold", 32'(sram_addr),   32'd1);
    chk("long_we_idle",   32'(sram_we),     32'd0);

    // BAD_CFG: num=0
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd0, '0, {39'd0, 13'd3});
    chk("bad_done_hi", 32'(done),     32'd1);
    chk("bad_tready",  32'(tready),   32'd0);
    chk("bad_err",     32'(err_code), 32'd1);
    tick();
    chk("bad_done_lo", 32'(done),      32'd0);
    chk("bad_ready",   32'(cfg_ready), 32'd1);
    // BAD_CFG: used tensor with len 0
    send_cfg(3'd2, {6'd0, 3'd1, 3'd2}, {26'd0, 13'd0, 13'd3});
    chk("bad_len0_err", 32'(err_code), 32'd1);
    // BAD_CFG: num above MAX_TENSORS
    idle(2);
    send_cfg(3'd5, '0, {13'd1, 13'd1, 13'd1, 13'd1});
    chk("bad_num5_err", 32'(err_code), 32'd1);
    idle(2);
    chk("bad_wr_cnt", 32'(wr_sel.size() - wb), 32'd0);

    // Abort during beat 2 of a len4 tensor, after a SHORT on tensor 0
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd2, {6'd0, 3'd6, 3'd4}, {26'd0, 13'd4, 13'd2});
    beat(8'h41, 1'b1);
    chk("abt_short_err", 32'(err_code), 32'd2);
    beat(8'h42, 1'b0);
    tdata = 8'h43; tlast = 1'b0; tvalid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; tvalid = 1'b0;
    chk("abt_ready", 32'(cfg_ready), 32'd1);
    chk("abt_busy",  32'(busy),      32'd0);
    chk("abt_err",   32'(err_code),  32'd2);
    chk("abt_done",  32'(done),      32'd0);
    tick();
    chk("abt_no_we", 32'(sram_we), 32'd0);
    idle(2);
    chk("abt_wr_cnt", 32'(wr_sel.size() - wb), 32'd2);
    chk_wr("abt_wr1", wb + 1, 3'd6, 13'd0, 8'h42);
    chk("abt_done_cnt", 32'(done_n - db), 32'd0);
    wb = wr_sel.size(); db = done_n;
    send_cfg(3'd1, {9'd0, 3'd7}, {39'd0, 13'd1});
    chk("abt_new_err_clr", 32'(err_code), 32'd0);
    beat(8'h51, 1'b1);
    idle(2);
    chk_wr("abt_new_wr", wb, 3'd7, 13'd0, 8'h51);
    chk("abt_new_done", 32'(done_n - db), 32'd1);

    // Asynchronous reset mid-LOAD
    wb = wr_sel.size();
    send_cfg(3'd1, {9'd0, 3'd1}, {39'd0, 13'd4});
    beat(8'h61, 1'b0);
    tdata = 8'h62; tvalid = 1'b1;
    #6;
    rst = 1'b1;
    #1;
    chk("arst_ready",  32'(cfg_ready),  32'd1);
    chk("arst_busy",   32'(busy),       32'd0);
    chk("arst_tready", 32'(tready),     32'd0);
    chk("arst_we",     32'(sram_we),    32'd0);
    chk("arst_cur",    32'(cur_tensor), 32'd0);
    chk("arst_addr",   32'(sram_addr),  32'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    tvalid = 1'b0;
    chk("arst_wr_cnt", 32'(wr_sel.size() - wb), 32'd1);
    chk_wr("arst_wr0", wb, 3'd1, 13'd0, 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
